// File: rtl/fir_sym_par.sv
// Symmetric-coefficient parallel FIR: pre-add, multiply, registered adder tree,
// then round/saturate. A valid tag rides alongside the data pipeline.

// One folded tap pair: registered pre-add of the mirrored samples, then a
// registered multiply by the shared coefficient.
module fir_sym_lane #(
    parameter int DW = 12,
    parameter int CW = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DW-1:0]    xa,
    input  logic signed [DW-1:0]    xb,
    input  logic signed [CW-1:0]    coef,
    output logic signed [DW+CW:0]   m
);
    localparam int PW = DW + 1;
    localparam int MW = DW + CW + 1;

    logic signed [PW-1:0] p;

    // Pre-add stage P feeding multiply stage M, both registered every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
            m <= '0;
        end else begin
            p <= PW'(xa) + PW'(xb);
            m <= MW'(p) * MW'(coef);
        end
    end
endmodule

module fir_sym_par #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int TAPS  = 16,
    parameter int OW    = 28,
    parameter int SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic signed [DW-1:0]          in_data,
    input  logic                          coef_we,
    input  logic [$clog2(TAPS/2)-1:0]     coef_addr,
    input  logic signed [CW-1:0]          coef_wdata,
    output logic                          out_valid,
    output logic signed [OW-1:0]          out_data,
    output logic                          sat
);
    localparam int HALF   = TAPS / 2;
    localparam int L      = $clog2(HALF);
    localparam int MW     = DW + CW + 1;
    localparam int FULL   = DW + CW + L + 1;
    localparam int STAGES = L + 3;
    // Working width for rounding/clipping: holds s plus carry, and the OW limits
    localparam int EW     = (FULL + 1 > OW + 1) ? FULL + 1 : OW + 1;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [DW-1:0]   x    [TAPS];
    logic signed [CW-1:0]   coef [HALF];
    logic signed [MW-1:0]   m    [HALF];
    logic signed [FULL-1:0] tr   [1:HALF-1];
    logic [STAGES:0]        vld_pipe;

    // Delay line: shifts only on accepted samples; clr flushes and wins over in_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (in_valid) begin
            x[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        end
    end

    // Coefficient bank: writes land mid-stream, no interlock with in-flight data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HALF; i++) coef[i] <= '0;
        end else if (coef_we) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Valid tag: stage 0 marks a sample just entered the delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_pipe <= '0;
        else if (clr) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    genvar g;
    generate
        for (g = 0; g < HALF; g++) begin : g_lane
            fir_sym_lane #(.DW(DW), .CW(CW)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .xa   (x[g]),
                .xb   (x[TAPS-1-g]),
                .coef (coef[g]),
                .m    (m[g])
            );
        end

        // Heap-indexed tree: node n sums children 2n, 2n+1; indices >= HALF are products
        for (g = 1; g < HALF; g++) begin : g_node
            logic signed [FULL-1:0] a, b;
            if (2 * g >= HALF) begin : g_leaf
                assign a = FULL'(m[2*g-HALF]);
                assign b = FULL'(m[2*g+1-HALF]);
            end else begin : g_inner
                assign a = tr[2*g];
                assign b = tr[2*g+1];
            end
            // One tree level per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) tr[g] <= '0;
                else     tr[g] <= a + b;
            end
        end
    endgenerate

    logic signed [EW-1:0] s_ext, r_ext;
    logic signed [OW-1:0] clip;
    logic                 sat_n;

    assign s_ext = EW'(tr[1]);

    generate
        if (SHIFT == 0) begin : g_noshift
            assign r_ext = s_ext;
        end else begin : g_shift
            // Round half up, then arithmetic shift
            assign r_ext = (s_ext + (EW'(1) <<< (SHIFT - 1))) >>> SHIFT;
        end
    endgenerate

    // Clip the scaled sum to the OW-bit signed range
    always_comb begin
        sat_n = 1'b0;
        clip  = r_ext[OW-1:0];
        if (r_ext > MAXV) begin
            clip  = {1'b0, {(OW-1){1'b1}}};
            sat_n = 1'b1;
        end else if (r_ext < MINV) begin
            clip  = {1'b1, {(OW-1){1'b0}}};
            sat_n = 1'b1;
        end
    end

    // Output register: data and sat hold between valid results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            sat      <= 1'b0;
        end else if (vld_pipe[STAGES-1]) begin
            out_data <= clip;
            sat      <= sat_n;
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule
